sudoku_grid_writer: RTL and testbench

Serialises a solved (or partial) 9x9 Sudoku grid of one-hot cell values as ASCII digits over an 8N1 UART line. It is the transmit-side counterpart of the grid reader: it accepts a grid snapshot on a start strobe, then streams it out in the same character format the reader accepts. The UART serialiser is built into the block. It replaces the ad-hoc per-cell transmit loop in the solver top level.

---
 rtl/sudoku_grid_writer.sv | 232 +++++++++++++++++++++++
 tb/tb_sudoku_grid_writer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_grid_writer.sv
// Streams a latched 9x9 one-hot Sudoku grid as ASCII digits over 8N1 UART.
// Optional SUDOKU_WRITER_CRLF_EN appends CR LF after every row (99-byte stream).
module sudoku_grid_writer #(
  parameter int p_CLKs_PB = 217
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Start,
  input  logic [8:0][8:0][8:0]   i_Grid,
  output logic                   o_Tx_UART,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Invalid
);

  localparam int CW = $clog2(p_CLKs_PB);
  localparam logic [CW-1:0] CNT_LAST = CW'(p_CLKs_PB - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

  function automatic logic [7:0] enc_cell(input logic [8:0] c);
    logic [7:0] b;
    b = 8'h30;
    for (int n = 0; n < 9; n++)
      if (c == (9'd1 << n)) b = 8'h31 + 8'(n);
    return b;
  endfunction

  function automatic logic multi_hot(input logic [8:0] c);
    return (c & (c - 9'd1)) != 9'd0;
  endfunction

  state_t                 state_q, state_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   inv_q, inv_d;
  logic [3:0]             row_q, row_d;
  logic [3:0]             col_q, col_d;
  logic [2:0]             bit_q, bit_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [8:0][8:0][8:0]   grid_q, grid_d;
`ifdef SUDOKU_WRITER_CRLF_EN
  logic [1:0]             sep_q, sep_d, nxt_sep;
`endif

  logic       cnt_end;
  logic       last_byte, is_digit, nxt_bad;
  logic [3:0] nxt_row, nxt_col;
  logic [7:0] nxt_byte;
  logic [8:0] nxt_cell;

  assign cnt_end = (cnt_q == CNT_LAST);

  // Byte that follows the current one in the stream, and whether it is the end.
  always_comb begin
    last_byte = 1'b0;
    is_digit  = 1'b1;
    nxt_row   = row_q;
    nxt_col   = col_q;
    nxt_byte  = 8'h30;
    nxt_bad   = 1'b0;
`ifdef SUDOKU_WRITER_CRLF_EN
    nxt_sep   = sep_q;
    case (sep_q)
      2'd0: begin
        if (col_q == 4'd8) begin
          nxt_sep  = 2'd1;
          is_digit = 1'b0;
          nxt_byte = 8'h0D;
        end else begin
          nxt_col = col_q + 4'd1;
        end
      end
      2'd1: begin
        nxt_sep  = 2'd2;
        is_digit = 1'b0;
        nxt_byte = 8'h0A;
      end
      default: begin
        if (row_q == 4'd8) begin
          last_byte = 1'b1;
          is_digit  = 1'b0;
        end else begin
          nxt_sep = 2'd0;
          nxt_row = row_q + 4'd1;
          nxt_col = 4'd0;
        end
      end
    endcase
`else
    if (col_q == 4'd8) begin
      if (row_q == 4'd8) begin
        last_byte = 1'b1;
        is_digit  = 1'b0;
      end else begin
        nxt_row = row_q + 4'd1;
        nxt_col = 4'd0;
      end
    end else begin
      nxt_col = col_q + 4'd1;
    end
`endif
    nxt_cell = grid_q[nxt_row][nxt_col];
    if (is_digit) begin
      nxt_byte = enc_cell(nxt_cell);
      nxt_bad  = multi_hot(nxt_cell);
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    inv_d   = inv_q;
    row_d   = row_q;
    col_d   = col_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    grid_d  = grid_q;
    cnt_d   = cnt_end ? '0 : cnt_q + 1'b1;
`ifdef SUDOKU_WRITER_CRLF_EN
    sep_d   = sep_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (i_Start) begin
          // Byte 0 comes straight from the input, as the snapshot lands on this same edge.
          grid_d  = i_Grid;
          shreg_d = enc_cell(i_Grid[0][0]);
          inv_d   = multi_hot(i_Grid[0][0]);
          row_d   = 4'd0;
          col_d   = 4'd0;
`ifdef SUDOKU_WRITER_CRLF_EN
          sep_d   = 2'd0;
`endif
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_end) begin
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end
      end
      S_STOP: begin
        if (cnt_end) begin
          if (last_byte) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            row_d   = nxt_row;
            col_d   = nxt_col;
`ifdef SUDOKU_WRITER_CRLF_EN
            sep_d   = nxt_sep;
`endif
            shreg_d = nxt_byte;
            inv_d   = inv_q | nxt_bad;
            tx_d    = 1'b0;
            state_d = S_START;
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inv_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
`ifdef SUDOKU_WRITER_CRLF_EN
      sep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      inv_q   <= inv_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
`ifdef SUDOKU_WRITER_CRLF_EN
      sep_q   <= sep_d;
`endif
    end
  end

  // Snapshot contents are don't-care after reset, so no reset term.
  always_ff @(posedge i_Clk) grid_q <= grid_d;

  assign o_Tx_UART = tx_q;
  assign o_Busy    = busy_q;
  assign o_Done    = done_q;
  assign o_Invalid = inv_q;

endmodule

// File: tb/tb_sudoku_grid_writer.sv
// Directed bench for sudoku_grid_writer at 4 clocks per bit, with a UART line monitor.
module tb_sudoku_grid_writer;
  localparam int P = 4;
`ifdef SUDOKU_WRITER_CRLF_EN
  localparam int N = 99, B_INV = 48, B_PRE = 47, RST_BIT = 0, LAT = 3961;
`else
  localparam int N = 81, B_INV = 40, B_PRE = 39, RST_BIT = 1, LAT = 3241;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [8:0][8:0][8:0] grid;
  logic tx, busy, done, inv;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, ferr = 0;
  bit rst_seen = 1'b0;
  logic [7:0] rxq[$];
  logic       inv_at[$];

  sudoku_grid_writer #(.p_CLKs_PB(P)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Grid(grid),
    .o_Tx_UART(tx), .o_Busy(busy), .o_Done(done), .o_Invalid(inv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt++;
  always @(posedge rst) rst_seen = 1'b1;

  // Detects a start bit on its first cycle and samples each later bit mid-way.
  always begin
    logic [7:0] b;
    logic       stp, iv;
    @(negedge clk);
    if (!rst && tx == 1'b0) begin
      rst_seen = 1'b0;
      iv = inv;
      repeat (5) @(negedge clk);
      b[0] = tx;
      for (int i = 1; i < 8; i++) begin
        repeat (4) @(negedge clk);
        b[i] = tx;
      end
      repeat (4) @(negedge clk);
      stp = tx;
      repeat (2) @(negedge clk);
      if (!rst_seen) begin
        rxq.push_back(b);
        inv_at.push_back(iv);
        if (stp !== 1'b1) ferr++;
      end
    end
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0][8:0][8:0] solved();
    logic [8:0][8:0][8:0] g;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        g[r][c] = 9'd1 << ((r * 3 + r / 3 + c) % 9);
    return g;
  endfunction

  function automatic logic [7:0] cell_ch(input logic [8:0] c);
    if ($countones(c) != 1) return 8'h30;
    for (int n = 0; n < 9; n++) if (c[n]) return 8'h31 + 8'(n);
    return 8'h30;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [8:0][8:0][8:0] g, input int k);
`ifdef SUDOKU_WRITER_CRLF_EN
    if (k % 11 == 9)  return 8'h0D;
    if (k % 11 == 10) return 8'h0A;
    return cell_ch(g[k / 11][k % 11]);
`else
    return cell_ch(g[k / 9][k % 9]);
`endif
  endfunction

  task automatic kick(output int t0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int t0, output int lat);
    bit found = 1'b0;
    for (int k = 0; k < 20000 && !found; k++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    if (!found) chk("done_timeout", 1'b0, 1'b1);
    // The interval after edge n is counted as cycle n+1.
    lat = cyc - t0 + 1;
    chk("busy_low_at_done", busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_stream(input string tag, input logic [8:0][8:0][8:0] g);
    int mism = 0;
    chk({tag, "_nbytes"}, rxq.size(), N);
    for (int k = 0; k < N && k < rxq.size(); k++)
      if (rxq[k] !== exp_byte(g, k)) mism++;
    chk({tag, "_bytes"}, mism, 0);
  endtask

  initial begin
    int t0, lat, dc, bad;
    logic [8:0][8:0][8:0] ga, gb;
    logic [71:0] row0;
    ga = solved();
    grid = ga;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_inv", inv, 1'b0);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle_hold", bad, 0);

    // Solved grid
    rxq.delete(); inv_at.delete(); dc = done_cnt;
    kick(t0);
    wait_done(t0, lat);
    chk("solved_latency", lat, LAT);
    chk("solved_inv", inv, 1'b0);
    chk_stream("solved", ga);
    row0 = '0;
    for (int k = 0; k < 9 && k < rxq.size(); k++) row0 = {row0[63:0], rxq[k]};
    chk("solved_row0", row0, "123456789");
    chk("solved_done_cnt", done_cnt - dc, 1);

    // Blank and multi-hot cells
    gb = ga;
    gb[0][0] = 9'd0;
    gb[4][4] = 9'b000000011;
    grid = gb;
    rxq.delete(); inv_at.delete();
    kick(t0);
    wait_done(t0, lat);
    chk_stream("invalid", gb);
    chk("inv_byte0", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h30);
    chk("inv_byte_bad", rxq.size() > B_INV ? rxq[B_INV] : 8'hxx, 8'h30);
    chk("inv_before_bad", inv_at.size() > B_PRE ? inv_at[B_PRE] : 1'bx, 1'b0);
    chk("inv_at_bad_start", inv_at.size() > B_INV ? inv_at[B_INV] : 1'bx, 1'b1);
    chk("inv_at_done", inv, 1'b1);

    // Snapshot isolation and start-while-busy
    grid = ga;
    rxq.delete(); inv_at.delete(); dc = done_cnt;
    kick(t0);
    @(negedge clk);
    chk("inv_cleared", inv, 1'b0);
    repeat (300) @(negedge clk);
    grid = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, lat);
    repeat (200) @(negedge clk);
    chk_stream("snapshot", ga);
    chk("snapshot_done_cnt", done_cnt - dc, 1);

    // Reset during byte 10 data bits
    grid = ga;
    rxq.delete(); inv_at.delete();
    kick(t0);
    while (cyc < t0 + 404 + 4 * RST_BIT + 1) @(negedge clk);
    chk("pre_rst_tx", tx, 1'b0);
    dc = done_cnt;
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - dc, 0);
    rxq.delete(); inv_at.delete();
    kick(t0);
    wait_done(t0, lat);
    chk("restart_latency", lat, LAT);
    chk_stream("restart", ga);
    chk("frame_errors", ferr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
